// File: rtl/stim_gen.sv
`default_nettype none
// ============================================================================
//  Module      : stim_gen
//  Description : Operand stimulus generator. Emits an optional fixed corner
//                table, then pseudo-random operand pairs from two Galois
//                LFSRs, for a programmed vector count. Optional feature macro:
//                STIM_CORNER_EN (defined = corner phase precedes random phase).
//  Revision    : 1.0 - initial release
// ============================================================================
module stim_gen #(
    parameter int          WIDTH       = 32,
    parameter int          NUM_VECTORS = 1024,
    parameter logic [31:0] SEED_A      = 32'hACE1_2468,
    parameter logic [31:0] SEED_B      = 32'h1357_BDF0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_hold,
    output logic [WIDTH-1:0] o_dut_ia,
    output logic [WIDTH-1:0] o_dut_ib,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [31:0]      o_vec_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CORNER = 2'd1,
        S_RANDOM = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] C_POLY    = 32'h8020_0003;
    localparam logic [31:0] C_SEED_A  = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
    localparam logic [31:0] C_SEED_B  = (SEED_B == 32'd0) ? 32'd1 : SEED_B;
    localparam logic [31:0] C_NUM_VEC = 32'(NUM_VECTORS);

`ifdef STIM_CORNER_EN
    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_MAX  = '1;
    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] C_MSB  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [3:0]       C_NUM_CORNER = 4'd8;
`endif

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? C_POLY : 32'd0);
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_operand(input logic [31:0] s);
        return WIDTH'({s, s});
    endfunction

`ifdef STIM_CORNER_EN
    // Returns {operand A, operand B} for corner index idx
    function automatic logic [2*WIDTH-1:0] corner_vec(input logic [2:0] idx);
        logic [2*WIDTH-1:0] v;
        v = {C_ZERO, C_ZERO};
        case (idx)
            3'd0: v = {C_ZERO, C_ZERO};
            3'd1: v = {C_ZERO, C_MAX};
            3'd2: v = {C_MAX,  C_ZERO};
            3'd3: v = {C_MAX,  C_MAX};
            3'd4: v = {C_ONE,  C_MAX};
            3'd5: v = {C_MSB,  C_MSB};
            3'd6: v = {C_MSB,  C_ONE};
            3'd7: v = {C_MAX,  C_ONE};
            default: v = {C_ZERO, C_ZERO};
        endcase
        return v;
    endfunction
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             valid_q, valid_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      lfsr_a_q, lfsr_a_d;
    logic [31:0]      lfsr_b_q, lfsr_b_d;
`ifdef STIM_CORNER_EN
    logic [3:0]       cidx_q, cidx_d;
`endif

    logic [31:0]      w_step_a;
    logic [31:0]      w_step_b;
    logic [31:0]      w_cnt_inc;
    logic [31:0]      w_seed_step_a;
    logic [31:0]      w_seed_step_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= 32'd0;
            lfsr_a_q <= C_SEED_A;
            lfsr_b_q <= C_SEED_B;
`ifdef STIM_CORNER_EN
            cidx_q   <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            lfsr_a_q <= lfsr_a_d;
            lfsr_b_q <= lfsr_b_d;
`ifdef STIM_CORNER_EN
            cidx_q   <= cidx_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        valid_d       = 1'b0;
        cnt_d         = cnt_q;
        lfsr_a_d      = lfsr_a_q;
        lfsr_b_d      = lfsr_b_q;
`ifdef STIM_CORNER_EN
        cidx_d        = cidx_q;
`endif
        w_step_a      = lfsr_step(lfsr_a_q);
        w_step_b      = lfsr_step(lfsr_b_q);
        w_seed_step_a = lfsr_step(C_SEED_A);
        w_seed_step_b = lfsr_step(C_SEED_B);
        w_cnt_inc     = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Start emits vector 0 on the same edge, from freshly seeded state
                if (i_start) begin
                    valid_d = 1'b1;
                    cnt_d   = 32'd1;
`ifdef STIM_CORNER_EN
                    {a_d, b_d} = corner_vec(3'd0);
                    cidx_d     = 4'd1;
                    lfsr_a_d   = C_SEED_A;
                    lfsr_b_d   = C_SEED_B;
                    state_d    = S_CORNER;
`else
                    a_d      = lfsr_operand(w_seed_step_a);
                    b_d      = lfsr_operand(w_seed_step_b);
                    lfsr_a_d = w_seed_step_a;
                    lfsr_b_d = w_seed_step_b;
                    state_d  = S_RANDOM;
`endif
                end
            end
            S_CORNER, S_RANDOM: begin
                if (!i_hold) begin
                    if (cnt_q >= C_NUM_VEC) begin
                        state_d = S_DONE;
                    end else begin
                        valid_d = 1'b1;
                        cnt_d   = w_cnt_inc;
`ifdef STIM_CORNER_EN
                        if ((state_q == S_CORNER) && (cidx_q < C_NUM_CORNER)) begin
                            {a_d, b_d} = corner_vec(cidx_q[2:0]);
                            cidx_d     = cidx_q + 4'd1;
                        end else begin
                            a_d      = lfsr_operand(w_step_a);
                            b_d      = lfsr_operand(w_step_b);
                            lfsr_a_d = w_step_a;
                            lfsr_b_d = w_step_b;
                            state_d  = S_RANDOM;
                        end
`else
                        a_d      = lfsr_operand(w_step_a);
                        b_d      = lfsr_operand(w_step_b);
                        lfsr_a_d = w_step_a;
                        lfsr_b_d = w_step_b;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_dut_ia  = a_q;
    assign o_dut_ib  = b_q;
    assign o_valid   = valid_q;
    assign o_busy    = (state_q == S_CORNER) || (state_q == S_RANDOM);
    assign o_done    = (state_q == S_DONE);
    assign o_vec_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stim_gen
//  Description : Scoreboard bench for stim_gen (WIDTH=8, NUM_VECTORS=12) plus
//                a zero-seed WIDTH=32 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stim_gen;

    localparam int N = 12;
`ifdef STIM_CORNER_EN
    localparam int NCORNER = 8;
`else
    localparam int NCORNER = 0;
`endif
    localparam int N2 = NCORNER + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic [7:0]  dut_a, dut_b;
    logic        dut_valid, dut_busy, dut_done;
    logic [31:0] dut_cnt;

    logic        start2 = 1'b0;
    logic [31:0] a2, b2, cnt2;
    logic        valid2, busy2, done2;

    always #5 clk = ~clk;

    stim_gen #(.WIDTH(8), .NUM_VECTORS(N)) u_dut (
        .clk(clk), .reset(rst_n), .i_start(start), .i_hold(hold),
        .o_dut_ia(dut_a), .o_dut_ib(dut_b), .o_valid(dut_valid),
        .o_busy(dut_busy), .o_done(dut_done), .o_vec_cnt(dut_cnt)
    );

    stim_gen #(.WIDTH(32), .NUM_VECTORS(N2), .SEED_A(32'h0)) u_dut2 (
        .clk(clk), .reset(rst_n), .i_start(start2), .i_hold(1'b0),
        .o_dut_ia(a2), .o_dut_ib(b2), .o_valid(valid2),
        .o_busy(busy2), .o_done(done2), .o_vec_cnt(cnt2)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [31:0] c;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] ea[N];
    logic [7:0] eb[N];
    int         n_cmp = 0;
    int         n_err = 0;

    // Hand-written corner table for WIDTH=8
    logic [7:0] corner_a[8] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h80, 8'h80, 8'hFF};
    logic [7:0] corner_b[8] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h80, 8'h01, 8'h01};

    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic [31:0] n;
        for (int i = 0; i < 31; i++) n[i] = s[i+1];
        n[31] = 1'b0;
        if (s[0]) n = n ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run();
        exp_t x;
        for (int i = 0; i < N; i++) begin
            x.a = ea[i];
            x.b = eb[i];
            x.c = 32'(i + 1);
            exp_q.push_back(x);
        end
    endtask

    task automatic pulse_start();
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_cnt(input logic [31:0] target, input string name);
        int k;
        k = 0;
        while (dut_cnt !== target && k < 60) begin
            tick();
            k++;
        end
        if (dut_cnt !== target) chk({name, "_timeout"}, dut_cnt, target);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (dut_done !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        chk({name, "_done"}, dut_done, 1);
    endtask

    task automatic check_done_state(input string name);
        chk({name, "_cnt"}, dut_cnt, N);
        chk({name, "_busy"}, dut_busy, 0);
        chk({name, "_valid"}, dut_valid, 0);
        chk({name, "_hold_a"}, dut_a, ea[N-1]);
        chk({name, "_hold_b"}, dut_b, eb[N-1]);
        chk({name, "_queue_left"}, exp_q.size(), 0);
    endtask

    // Monitor: every presented vector must match the next scoreboard entry
    always @(negedge clk) begin
        if (rst_n && dut_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("vec_a", dut_a, e.a);
                chk("vec_b", dut_b, e.b);
                chk("vec_cnt", dut_cnt, e.c);
            end
        end
    end

    initial begin
        logic [31:0] la, lb;
        la = 32'hACE1_2468;
        lb = 32'h1357_BDF0;
        for (int i = 0; i < N; i++) begin
            if (i < NCORNER) begin
                ea[i] = corner_a[i];
                eb[i] = corner_b[i];
            end else begin
                la = m_step(la);
                lb = m_step(lb);
                ea[i] = la[7:0];
                eb[i] = lb[7:0];
            end
        end

        // Reset and idle
        repeat (3) tick();
        chk("rst_a", dut_a, 0);
        chk("rst_cnt", dut_cnt, 0);
        chk("rst_flags", {dut_valid, dut_busy, dut_done}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_outputs", {dut_a, dut_b, dut_valid, dut_busy, dut_done, dut_cnt}, 0);
        end

        // Run 1: full sequence; first random vector against hand values
        pulse_start();
        chk("run1_busy", dut_busy, 1);
        wait_cnt(32'(NCORNER + 1), "run1_first_rand");
        chk("first_rand_a", dut_a, 8'h34);
        chk("first_rand_b", dut_b, 8'hF8);
        wait_done("run1");
        check_done_state("run1");
        repeat (3) tick();
        chk("done_held", {dut_done, dut_cnt}, {1'b1, 32'(N)});

        // Run 2: restart from DONE with a 5-cycle hold mid-RANDOM
        pulse_start();
        chk("run2_done_clear", dut_done, 0);
        chk("run2_cnt_restart", dut_cnt, 1);
        wait_cnt(32'(NCORNER + 1), "run2_hold_point");
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", dut_valid, 0);
            chk("hold_cnt", dut_cnt, NCORNER + 1);
            chk("hold_vec", {dut_a, dut_b}, {ea[NCORNER], eb[NCORNER]});
        end
        hold = 1'b0;
        wait_done("run2");
        check_done_state("run2");

        // Run 3: start while busy is ignored
        pulse_start();
        wait_cnt(32'd4, "run3_vec3");
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_cnt", dut_cnt, 5);
        wait_done("run3");
        check_done_state("run3");

        // Run 4: asynchronous reset mid-run
        pulse_start();
        wait_cnt(32'd6, "run4_vec5");
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {dut_a, dut_b, dut_valid, dut_busy, dut_done, dut_cnt}, 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();

        // Run 5: start and hold together in IDLE
        push_run();
        start = 1'b1;
        hold  = 1'b1;
        tick();
        start = 1'b0;
        chk("sh_first_valid", dut_valid, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sh_hold_valid", dut_valid, 0);
            chk("sh_hold_cnt", dut_cnt, 1);
        end
        hold = 1'b0;
        wait_done("run5");
        check_done_state("run5");

        // Zero-seed instance: first random vector from seed 1
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 40 && done2 !== 1'b1; k++) tick();
        chk("seed0_done", done2, 1);
        chk("seed0_a", a2, 32'h8020_0003);
        chk("seed0_b", b2, 32'h09AB_DEF8);
        chk("seed0_cnt", cnt2, N2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
